// File: rtl/bist_pkg.sv
// Shared definitions for the BIST fail logger: run-state encodings
// and default geometry of the logged RAM.
package bist_pkg;

    typedef enum logic [1:0] {
        RS_IDLE = 2'b00,
        RS_RUN  = 2'b01,
        RS_DONE = 2'b10
    } run_state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_CNT_W  = 12;

endpackage

// File: rtl/bist_log_fifo.sv
// Generic synchronous FIFO holding fail-log entries. Head is shown
// combinationally; reads as zero while empty. clr drops all entries.
module bist_log_fifo
    import bist_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W + 2 * DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still
    // accept a push; a pop on an empty FIFO is ignored.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; clearing outranks any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; no reset needed since empty masks the output.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bist_fail_logger.sv
// Logs BIST compare mismatches into a FIFO with count/overflow/state.
// Define BIST_FAIL_BITMAP_EN to add the accumulated fail_bitmap output.
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_active,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_expected,
    input  logic [DATA_W-1:0] cmp_actual,
    input  logic              log_pop,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_expected,
    output logic [DATA_W-1:0] log_actual,
    output logic [CNT_W-1:0]  err_count,
    output logic              log_overflow,
    output logic [1:0]        run_state
`ifdef BIST_FAIL_BITMAP_EN
    ,
    output logic [DATA_W-1:0] fail_bitmap
`endif
);

    localparam int EW = ADDR_W + 2 * DATA_W;

    run_state_t    state;
    run_state_t    state_nx;
    logic          ta_prev;
    logic          armed;
    logic          rise;
    logic          fall;
    logic          run_entry;
    logic          mismatch;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] head;

    assign rise      = test_active && !ta_prev && armed;
    assign fall      = !test_active && ta_prev;
    assign run_entry = rise && (state != RS_RUN);
    assign mismatch  = cmp_valid && (state == RS_RUN) &&
                       (cmp_expected != cmp_actual);
    assign drop      = mismatch && fifo_full && !log_pop;

    // Edge detector. armed blocks a fake rising edge when test_active
    // is already high through reset; it needs to see a low first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ta_prev <= 1'b0;
            armed   <= !test_active;
        end else begin
            ta_prev <= test_active;
            if (!test_active) armed <= 1'b1;
        end
    end

    // Run-state register.
    always_ff @(posedge clk) begin
        if (rst) state <= RS_IDLE;
        else     state <= state_nx;
    end

    // Run-state transitions on test_active edges.
    always_comb begin
        state_nx = state;
        unique case (state)
            RS_IDLE, RS_DONE: if (rise) state_nx = RS_RUN;
            RS_RUN:           if (fall) state_nx = RS_DONE;
            default:          state_nx = RS_IDLE;
        endcase
    end

    // Saturating error count and sticky overflow, cleared per run.
    always_ff @(posedge clk) begin
        if (rst || run_entry) begin
            err_count    <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (mismatch && (err_count != '1))
                err_count <= err_count + 1'b1;
            if (drop)
                log_overflow <= 1'b1;
        end
    end

`ifdef BIST_FAIL_BITMAP_EN
    // Bit positions that failed at least once this run.
    always_ff @(posedge clk) begin
        if (rst || run_entry)
            fail_bitmap <= '0;
        else if (mismatch)
            fail_bitmap <= fail_bitmap | (cmp_expected ^ cmp_actual);
    end
`endif

    bist_log_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_entry),
        .push  (mismatch),
        .wdata ({cmp_addr, cmp_expected, cmp_actual}),
        .pop   (log_pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign log_valid    = !fifo_empty;
    assign log_addr     = head[EW-1 -: ADDR_W];
    assign log_expected = head[2*DATA_W-1 -: DATA_W];
    assign log_actual   = head[DATA_W-1:0];
    assign run_state    = state;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Self-checking bench for bist_fail_logger: a vector table plus a
// scoreboard of expected log entries, with a CNT_W=3 twin for saturation.
module tb_bist_fail_logger;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          test_active;
    logic          cmp_valid;
    logic [AW-1:0] cmp_addr;
    logic [DW-1:0] cmp_expected;
    logic [DW-1:0] cmp_actual;
    logic          log_pop;
    logic          log_valid;
    logic [AW-1:0] log_addr;
    logic [DW-1:0] log_expected;
    logic [DW-1:0] log_actual;
    logic [11:0]   err_count;
    logic          log_overflow;
    logic [1:0]    run_state;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_exp;
    logic [DW-1:0] s_act;
    logic [2:0]    s_count;
    logic          s_ovf;
    logic [1:0]    s_state;
`ifdef BIST_FAIL_BITMAP_EN
    logic [DW-1:0] fail_bitmap;
    logic [DW-1:0] s_bitmap;
`endif

    always #5 clk = ~clk;

    bist_fail_logger u_dut (
        .clk          (clk),
        .rst          (rst),
        .test_active  (test_active),
        .cmp_valid    (cmp_valid),
        .cmp_addr     (cmp_addr),
        .cmp_expected (cmp_expected),
        .cmp_actual   (cmp_actual),
        .log_pop      (log_pop),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_expected (log_expected),
        .log_actual   (log_actual),
        .err_count    (err_count),
        .log_overflow (log_overflow),
        .run_state    (run_state)
`ifdef BIST_FAIL_BITMAP_EN
        ,
        .fail_bitmap  (fail_bitmap)
`endif
    );

    bist_fail_logger #(.CNT_W(3)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .test_active  (test_active),
        .cmp_valid    (cmp_valid),
        .cmp_addr     (cmp_addr),
        .cmp_expected (cmp_expected),
        .cmp_actual   (cmp_actual),
        .log_pop      (log_pop),
        .log_valid    (s_valid),
        .log_addr     (s_addr),
        .log_expected (s_exp),
        .log_actual   (s_act),
        .err_count    (s_count),
        .log_overflow (s_ovf),
        .run_state    (s_state)
`ifdef BIST_FAIL_BITMAP_EN
        ,
        .fail_bitmap  (s_bitmap)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        logic [DW-1:0] r;
    } ent_t;

    typedef struct {
        bit            ta;
        bit            cv;
        logic [AW-1:0] ad;
        logic [DW-1:0] e;
        logic [DW-1:0] a;
        bit            pop;
        bit            xv;
        int            xc;
        logic [1:0]    xs;
    } vec_t;

    ent_t       sb[$];
    vec_t       tbl[5];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         m_prev;
    bit         m_armed;
    logic [1:0] m_state;
    int         m_cnt;
    int         m_cnt_s;
    bit         m_ovf;
    logic [7:0] m_bm;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
        end
    endtask

    task automatic chk_outputs();
        chk("log_valid", 32'(log_valid), 32'(sb.size() > 0));
        chk("err_count", 32'(err_count), m_cnt);
        chk("log_overflow", 32'(log_overflow), 32'(m_ovf));
        chk("run_state", 32'(run_state), 32'(m_state));
        chk("sat_count", 32'(s_count), m_cnt_s);
        if (sb.size() > 0) begin
            chk("head_addr", 32'(log_addr), 32'(sb[0].a));
            chk("head_exp", 32'(log_expected), 32'(sb[0].e));
            chk("head_act", 32'(log_actual), 32'(sb[0].r));
        end
`ifdef BIST_FAIL_BITMAP_EN
        chk("fail_bitmap", 32'(fail_bitmap), 32'(m_bm));
`endif
    endtask

    task automatic do_reset(input bit ta);
        rst = 1'b1;
        test_active = ta;
        cmp_valid = 1'b0;
        log_pop = 1'b0;
        cmp_addr = '0;
        cmp_expected = '0;
        cmp_actual = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_prev = 1'b0;
        m_armed = !ta;
        m_state = 2'b00;
        m_cnt = 0;
        m_cnt_s = 0;
        m_ovf = 1'b0;
        m_bm = '0;
        chk_outputs();
        chk("rst_addr", 32'(log_addr), 0);
        chk("rst_exp", 32'(log_expected), 0);
        chk("rst_act", 32'(log_actual), 0);
    endtask

    task automatic step(input bit ta, input bit cv,
                        input logic [AW-1:0] ad,
                        input logic [DW-1:0] e,
                        input logic [DW-1:0] a,
                        input bit pop);
        bit rise;
        bit fall;
        bit mm;
        bit popa;
        test_active = ta;
        cmp_valid = cv;
        cmp_addr = ad;
        cmp_expected = e;
        cmp_actual = a;
        log_pop = pop;
        rise = ta && !m_prev && m_armed;
        fall = !ta && m_prev;
        mm = cv && (m_state == 2'b01) && (e != a);
        popa = pop && (sb.size() > 0);
        if (rise && m_state != 2'b01) begin
            sb.delete();
            m_cnt = 0;
            m_cnt_s = 0;
            m_ovf = 1'b0;
            m_bm = '0;
            m_state = 2'b01;
        end else begin
            if (popa) void'(sb.pop_front());
            if (mm) begin
                if (sb.size() < DEPTH) sb.push_back({ad, e, a});
                else m_ovf = 1'b1;
                if (m_cnt < 4095) m_cnt++;
                if (m_cnt_s < 7) m_cnt_s++;
                m_bm = m_bm | (e ^ a);
            end
            if (fall && m_state == 2'b01) m_state = 2'b10;
        end
        if (!ta) m_armed = 1'b1;
        m_prev = ta;
        @(posedge clk);
        #1;
        chk_outputs();
        cmp_valid = 1'b0;
        log_pop = 1'b0;
    endtask

    task automatic restart();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{0, 1, 10'h000, 8'h55, 8'h54, 0, 0, 0, 2'b00};
        tbl[1] = '{1, 1, 10'h03A, 8'hAA, 8'hAB, 0, 0, 0, 2'b01};
        tbl[2] = '{1, 1, 10'h03A, 8'hAA, 8'hAB, 0, 1, 1, 2'b01};
        tbl[3] = '{1, 0, 10'h000, 8'h00, 8'h00, 1, 0, 1, 2'b01};
        tbl[4] = '{1, 1, 10'h005, 8'h12, 8'h12, 0, 0, 1, 2'b01};

        do_reset(1'b0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pop && log_valid) begin
                chk("tbl_addr", 32'(log_addr), 32'h03A);
                chk("tbl_exp", 32'(log_expected), 32'hAA);
                chk("tbl_act", 32'(log_actual), 32'hAB);
            end
            step(tbl[i].ta, tbl[i].cv, tbl[i].ad,
                 tbl[i].e, tbl[i].a, tbl[i].pop);
            chk("tbl_valid", 32'(log_valid), 32'(tbl[i].xv));
            chk("tbl_count", 32'(err_count), tbl[i].xc);
            chk("tbl_state", 32'(run_state), 32'(tbl[i].xs));
        end

        restart();
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 10'(10'h100 + i), 8'(i), 8'(i ^ 8'h5A), 1'b0);
        chk("ovf_count", 32'(err_count), 10);
        chk("ovf_flag", 32'(log_overflow), 1);
        chk("ovf_sat", 32'(s_count), 7);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk("done_state", 32'(run_state), 32'h2);
        chk("done_valid", 32'(log_valid), 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", 32'(log_addr), 32'(10'h100 + i));
            step(1'b0, 1'b0, '0, '0, '0, 1'b1);
        end
        chk("drained", 32'(log_valid), 0);

        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 10'(10'h200 + i), 8'hF0, 8'(i), 1'b0);
        step(1'b1, 1'b1, 10'h2AA, 8'h11, 8'h22, 1'b1);
        chk("simul_ovf", 32'(log_overflow), 0);
        chk("simul_cnt", 32'(err_count), 9);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk("rs_done", 32'(run_state), 32'h2);
        chk("rs_readable", 32'(log_addr), 32'h201);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        chk("rs_valid", 32'(log_valid), 0);
        chk("rs_count", 32'(err_count), 0);
        chk("rs_ovf", 32'(log_overflow), 0);
        chk("rs_state", 32'(run_state), 32'h1);

        step(1'b1, 1'b1, 10'h011, 8'h00, 8'h01, 1'b0);
        step(1'b1, 1'b1, 10'h022, 8'h00, 8'h80, 1'b0);
`ifdef BIST_FAIL_BITMAP_EN
        chk("bitmap", 32'(fail_bitmap), 32'h81);
`endif

        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 10'(10'h300 + i), 8'h0F, 8'h0E, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, '0, '0, '0, 1'b1);
        step(1'b1, 1'b1, 10'h3FF, 8'h33, 8'h34, 1'b1);
        chk("empty_simul", 32'(log_addr), 32'h3FF);

        do_reset(1'b1);
        step(1'b1, 1'b1, 10'h001, 8'h01, 8'h02, 1'b0);
        step(1'b1, 1'b1, 10'h002, 8'h01, 8'h02, 1'b0);
        chk("norun_state", 32'(run_state), 0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0);
        chk("rerun_state", 32'(run_state), 1);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
